// File: rtl/pipe_fetch_stage.sv
// RV32I instruction-fetch stage: PC, synchronous IMEM interface and IF/ID register.
// Optional stall/flush performance counters enabled by defining FETCH_PERF_CNT_EN.
module pipe_fetch_stage #(
  parameter int unsigned REG_DATA_WIDTH     = 32,
  parameter int unsigned REGFILE_ADDR_WIDTH = 5,
  parameter logic [REG_DATA_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [REG_DATA_WIDTH-1:0]     IMEM_addr,
  input  logic [REG_DATA_WIDTH-1:0]     IMEM_data,
  input  logic                          Stall,
  input  logic                          IF_ID_Flush,
  input  logic                          EX_PC_Branch,
  input  logic [REG_DATA_WIDTH-1:0]     EX_Branch_target,
  input  logic                          ID_Jump,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Jump_target,
  output logic [REG_DATA_WIDTH-1:0]     IF_PC,
  output logic [REG_DATA_WIDTH-1:0]     IF_Instruction,
  output logic [REGFILE_ADDR_WIDTH-1:0] IF_Rs1_addr,
  output logic [REGFILE_ADDR_WIDTH-1:0] IF_Rs2_addr,
  output logic                          IF_Valid,
  output logic [31:0]                   Stall_count,
  output logic [31:0]                   Flush_count
);

  localparam int unsigned W = REG_DATA_WIDTH;
  localparam logic [W-1:0] NOP        = W'(32'h0000_0013);
  localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

  logic [W-1:0] pc_q;
  logic [W-1:0] fetch_pc_q;
  logic         fetch_valid_q;
  logic [W-1:0] if_pc_q;
  logic [W-1:0] if_instr_q;
  logic         if_valid_q;

  logic         redirect;
  logic [W-1:0] redirect_target;

  // EX branch outranks the ID jump: the jump sits on the wrong path.
  assign redirect        = EX_PC_Branch | ID_Jump;
  assign redirect_target = EX_PC_Branch ? EX_Branch_target : ID_Jump_target;

  // While stalled, re-read the word already on IMEM_data so it stays valid.
  assign IMEM_addr = (Stall && !redirect) ? fetch_pc_q : pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= PC_RESET & ALIGN_MASK;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= NOP;
      if_valid_q    <= 1'b0;
    end else if (redirect) begin
      pc_q          <= redirect_target & ALIGN_MASK;
      fetch_valid_q <= 1'b0;
      if_instr_q    <= NOP;
      if_valid_q    <= 1'b0;
    end else if (!Stall || IF_ID_Flush) begin
      fetch_pc_q    <= pc_q;
      fetch_valid_q <= 1'b1;
      pc_q          <= pc_q + W'(4);
      if (IF_ID_Flush || !fetch_valid_q) begin
        if_instr_q <= NOP;
        if_valid_q <= 1'b0;
      end else begin
        if_pc_q    <= fetch_pc_q;
        if_instr_q <= IMEM_data;
        if_valid_q <= 1'b1;
      end
    end
  end

  assign IF_PC          = if_pc_q;
  assign IF_Instruction = if_instr_q;
  assign IF_Valid       = if_valid_q;
  assign IF_Rs1_addr    = if_instr_q[15 +: REGFILE_ADDR_WIDTH];
  assign IF_Rs2_addr    = if_instr_q[20 +: REGFILE_ADDR_WIDTH];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall && !redirect)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect || IF_ID_Flush)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign Stall_count = stall_cnt_q;
  assign Flush_count = flush_cnt_q;
`else
  assign Stall_count = '0;
  assign Flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: cycle table on a default instance plus
// a hand-written PC wrap sequence on an instance reset near the top of memory.
module tb_pipe_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic        br;
  logic [31:0] br_tgt;
  logic        jmp;
  logic [31:0] jmp_tgt;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        if_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic        w_rst;
  logic        w_zero;
  logic [31:0] w_zero32;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_if_valid;
  logic [31:0] w_stall_cnt;
  logic [31:0] w_flush_cnt;

  int unsigned n_checks;
  int unsigned n_fail;

  pipe_fetch_stage dut (
    .clk(clk), .rst(rst), .IMEM_addr(imem_addr), .IMEM_data(imem_data),
    .Stall(stall), .IF_ID_Flush(flush), .EX_PC_Branch(br),
    .EX_Branch_target(br_tgt), .ID_Jump(jmp), .ID_Jump_target(jmp_tgt),
    .IF_PC(if_pc), .IF_Instruction(if_instr), .IF_Rs1_addr(rs1),
    .IF_Rs2_addr(rs2), .IF_Valid(if_valid), .Stall_count(stall_cnt),
    .Flush_count(flush_cnt)
  );

  pipe_fetch_stage #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(w_rst), .IMEM_addr(w_imem_addr), .IMEM_data(w_imem_data),
    .Stall(w_zero), .IF_ID_Flush(w_zero), .EX_PC_Branch(w_zero),
    .EX_Branch_target(w_zero32), .ID_Jump(w_zero), .ID_Jump_target(w_zero32),
    .IF_PC(w_if_pc), .IF_Instruction(w_if_instr), .IF_Rs1_addr(w_rs1),
    .IF_Rs2_addr(w_rs2), .IF_Valid(w_if_valid), .Stall_count(w_stall_cnt),
    .Flush_count(w_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8) ? 32'h0020_8133 : a;
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) begin
    imem_data   <= mem_word(imem_addr);
    w_imem_data <= w_imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r, s, f, b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        ca;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } vec_t;

  function automatic vec_t mk(input logic r, s, f, b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic ca, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc, instr, scnt, fcnt);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.b = b; v.bt = bt; v.j = j; v.jt = jt;
    v.ca = ca; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
    v.scnt = scnt; v.fcnt = fcnt;
    return v;
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t vecs[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0;
    br_tgt = '0; jmp_tgt = '0;
    w_rst = 1'b1; w_zero = 1'b0; w_zero32 = '0;

    //            r  s  f  b  bt      j  jt     ca addr     v  pc       instr         sc fc
    vecs.push_back(mk(1, 0, 0, 0, 0,     0, 0,     0, 0,      0, 0,      NOP,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 0,      0, 0,      NOP,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 4,      1, 0,      0,            0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 8,      1, 4,      4,            0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 12,     1, 8,      32'h0020_8133,0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,     0, 0,     1, 12,     1, 8,      32'h0020_8133,1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,     0, 0,     1, 12,     1, 8,      32'h0020_8133,2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,     0, 0,     1, 12,     1, 8,      32'h0020_8133,3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 16,     1, 12,     12,           3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 20,     1, 16,     16,           3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 24,     1, 20,     20,           3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     1, 'h103, 1, 28,     0, 20,     NOP,          3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h100,  0, 20,     NOP,          3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h104,  1, 'h100,  'h100,        3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h108,  1, 'h104,  'h104,        3, 1));
    vecs.push_back(mk(0, 1, 0, 1, 'h40,  1, 'h80,  1, 'h10C,  0, 'h104,  NOP,          3, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h40,   0, 'h104,  NOP,          3, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h44,   1, 'h40,   'h40,         3, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0,     0, 0,     1, 'h48,   0, 'h40,   NOP,          3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h4C,   1, 'h48,   'h48,         3, 3));
    vecs.push_back(mk(0, 0, 0, 1, 'h202, 0, 0,     1, 'h50,   0, 'h48,   NOP,          3, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0,     0, 0,     0, 0,      0, 'h48,   NOP,          4, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h200,  0, 'h48,   NOP,          4, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 'h204,  1, 'h200,  'h200,        4, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0,     0, 0,     1, 'h204,  1, 'h200,  'h200,        5, 4));
    vecs.push_back(mk(1, 1, 0, 0, 0,     0, 0,     0, 0,      0, 0,      NOP,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 0,      0, 0,      NOP,          0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 4,      1, 0,      0,            0, 0));

    foreach (vecs[i]) begin
      logic [31:0] ei;
      ei = vecs[i].instr;
      @(negedge clk);
      rst = vecs[i].r; stall = vecs[i].s; flush = vecs[i].f;
      br = vecs[i].b; br_tgt = vecs[i].bt; jmp = vecs[i].j; jmp_tgt = vecs[i].jt;
      #1;
      if (vecs[i].ca)
        chk($sformatf("imem_addr[%0d]", i), imem_addr, vecs[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("if_valid[%0d]", i), 32'(if_valid), 32'(vecs[i].valid));
      chk($sformatf("if_pc[%0d]", i), if_pc, vecs[i].pc);
      chk($sformatf("if_instr[%0d]", i), if_instr, ei);
      chk($sformatf("rs1[%0d]", i), 32'(rs1), 32'(ei[19:15]));
      chk($sformatf("rs2[%0d]", i), 32'(rs2), 32'(ei[24:20]));
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("stall_cnt[%0d]", i), stall_cnt, vecs[i].scnt);
      chk($sformatf("flush_cnt[%0d]", i), flush_cnt, vecs[i].fcnt);
`else
      chk($sformatf("stall_cnt[%0d]", i), stall_cnt, 32'd0);
      chk($sformatf("flush_cnt[%0d]", i), flush_cnt, 32'd0);
`endif
    end

    // PC wrap from the top of the address space on the second instance.
    @(negedge clk);
    w_rst = 1'b1;
    @(posedge clk); #1;
    chk("wrap_reset_valid", 32'(w_if_valid), 32'd0);
    @(negedge clk);
    w_rst = 1'b0;
    #1 chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap_bubble_valid", 32'(w_if_valid), 32'd0);
    @(negedge clk); #1;
    chk("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_pc0", w_if_pc, 32'hFFFF_FFF8);
    chk("wrap_valid0", 32'(w_if_valid), 32'd1);
    chk("wrap_instr0", w_if_instr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("wrap_addr2", w_imem_addr, 32'h0000_0000);
    @(posedge clk); #1;
    chk("wrap_pc1", w_if_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap_pc2", w_if_pc, 32'h0000_0000);
    chk("wrap_instr2", w_if_instr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
